// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state type, default table and half-period lookup for clk_div_prog
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_CNT_W     = 25;
    localparam int DEF_NUM_MODES = 4;
    localparam logic [DEF_NUM_MODES*DEF_CNT_W-1:0] DEF_HALF_TABLE = {
        25'd25_000_000, 25'd12_500_000, 25'd6_250_000, 25'd3_125_000
    };

    // Tables are zero-extended to this width so one lookup serves every parameterisation.
    localparam int TBL_MAX_W = 1024;

    function automatic logic [31:0] half_of(
        input logic [TBL_MAX_W-1:0] tbl,
        input int unsigned          idx,
        input int unsigned          num_modes = DEF_NUM_MODES,
        input int unsigned          cnt_w     = DEF_CNT_W
    );
        int unsigned          sel;
        logic [TBL_MAX_W-1:0] shifted;
        logic [31:0]          mask;
        sel     = (idx >= num_modes) ? num_modes - 1 : idx;
        shifted = tbl >> (sel * cnt_w);
        mask    = (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
        return shifted[31:0] & mask;
    endfunction

    function automatic bit table_ok(
        input logic [TBL_MAX_W-1:0] tbl,
        input int unsigned          num_modes,
        input int unsigned          cnt_w
    );
        for (int unsigned i = 0; i < num_modes; i++) begin
            if (half_of(tbl, i, num_modes, cnt_w) < 32'd2) return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable square-wave divider with tick, drain-on-stop and edge-aligned mode switch
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int                              CNT_W      = DEF_CNT_W,
    parameter int                              NUM_MODES  = DEF_NUM_MODES,
    parameter int                              MODE_W     = $clog2(NUM_MODES),
    parameter logic [NUM_MODES*CNT_W-1:0]      HALF_TABLE = DEF_HALF_TABLE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    output logic              out,
    output logic              tick,
    output logic [MODE_W-1:0] mode_q,
    output logic              busy
);

    localparam logic [TBL_MAX_W-1:0] TABLE_EXT = TBL_MAX_W'(HALF_TABLE);
    localparam bit TABLE_OK = table_ok(TABLE_EXT, NUM_MODES, CNT_W);

    generate
        if (!TABLE_OK || CNT_W > 32 || NUM_MODES * CNT_W > TBL_MAX_W) begin : g_bad_cfg
            $error("clk_div_prog: every HALF_TABLE entry must lie in [2, 2**CNT_W-1]");
        end
    endgenerate

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [CNT_W-1:0]  half_m1;
    logic              out_n, tick_n, at_edge;
    logic [MODE_W-1:0] mode_n;

    // Only the latched mode sets the running half period, so mid-period requests wait for the edge.
    assign half_m1 = CNT_W'(half_of(TABLE_EXT, 32'(mode_q), NUM_MODES, CNT_W) - 32'd1);
    assign at_edge = (cnt == half_m1);
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            out    <= 1'b0;
            tick   <= 1'b0;
            mode_q <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            out    <= out_n;
            tick   <= tick_n;
            mode_q <= mode_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        out_n   = out;
        tick_n  = 1'b0;
        mode_n  = mode_q;
        case (state)
            ST_IDLE: begin
                out_n = 1'b0;
                cnt_n = '0;
                if (en) begin
                    state_n = ST_RUN;
                    mode_n  = mode;
                end
            end
            ST_RUN: begin
                if (at_edge) begin
                    cnt_n  = '0;
                    out_n  = ~out;
                    tick_n = 1'b1;
                    mode_n = mode;
                    // The toggle wins over a simultaneous stop; a fresh high phase still drains.
                    if (!en) state_n = out ? ST_IDLE : ST_DRAIN;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    if (!en) begin
                        if (out) begin
                            state_n = ST_DRAIN;
                        end else begin
                            state_n = ST_IDLE;
                            cnt_n   = '0;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (at_edge) begin
                    cnt_n   = '0;
                    out_n   = 1'b0;
                    tick_n  = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                out_n   = 1'b0;
            end
        endcase
    end

endmodule
